// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, the supported opcodes, and the encodings
// of the ALU source-B, ALU operation and PC source multiplexer selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_decode.sv
// mc_output_decode: purely combinational control-output decoder.
// Ports:
//   reset       in   forces every strobe/select to 0 while high
//   state       in   registered FSM state
//   opcode      in   IR opcode, used only for the DECODE-state illegal pulse
//   zero        in   ALU zero flag (branch PC enable)
//   mem_ready   in   memory handshake (FETCH PC/IR enables, MEMWR retire)
//   pc_en .. illegal_op  out  datapath control strobes and selects
module mc_output_decode
    import mips_mc_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    always_comb begin
        // NOTE: every output is given its inactive value before the case,
        // so no state leaves one unassigned and no latch is inferred.
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    // Only opcode-dependent outputs: an unknown opcode retires here.
                    illegal_op = !is_legal_op(opcode);
                    instr_done = !is_legal_op(opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALUOP_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ; // encodings 12-15: everything stays inactive
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore control FSM for a multicycle MIPS
// datapath sharing one memory port and one ALU.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode                IR[31:26], valid from DECODE onward
//   zero, mem_ready       ALU zero flag, memory completion handshake
//   pc_en .. pc_src       datapath strobes and mux selects
//   instr_done            one-cycle retire pulse
//   illegal_op            one-cycle pulse on an unsupported opcode
//   instr_count           retired instructions (wraps), illegal ones included
//   state                 current state encoding for debug
module mips_multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH; // retire states and 12-15
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so state and counter both sample
        // the pre-edge values and update together.
        if (reset) begin
            state_q     <= S_FETCH;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done)
                instr_count <= instr_count + COUNT_W'(1);
        end
    end

    assign state = state_q;

    mc_output_decode u_decode (
        .reset      (reset),
        .state      (state_q),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed testbench for mips_multicycle_controller (COUNT_W = 4 so the
// retire counter wrap is reachable in a short run). Each cycle compares the
// state and the full control vector against hand-computed constants.
// Control vector bit order:
//   pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write
//   alu_src_a alu_src_b[1:0] alu_op[1:0] pc_src[1:0] instr_done illegal_op
module tb_mips_multicycle_controller;

    localparam logic [16:0] C_ZERO     = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_FETCH_R  = 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] C_FETCH_W  = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [16:0] C_MEMADR   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [16:0] C_MEMRD    = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_MEMWB    = 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [16:0] C_MEMWR_W  = 17'b0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_MEMWR_R  = 17'b0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [16:0] C_EXECUTE  = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [16:0] C_ALUWB    = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [16:0] C_BR_Z1    = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] C_BR_Z0    = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] C_ADDIEX   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [16:0] C_ADDIWB   = 17'b0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [16:0] C_JUMP     = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] instr_count;
    logic [3:0] state;
    logic [16:0] ctrl;

    int vectors;
    int miscompares;

    assign ctrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};

    mips_multicycle_controller #(.COUNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_ZERO) begin
            miscompares++;
            $display("FAIL reset_outputs: ctrl=%b expected=%b", ctrl, C_ZERO);
        end
        next_cycle();
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d count=%0d expected state=0 count=0", state, instr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        logic [16:0] ex [4] = '{C_FETCH_R, C_DECODE, C_ADDIEX, C_ADDIWB};
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL addi cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd1) begin
            miscompares++;
            $display("FAIL addi_retire: state=%0d count=%0d expected state=0 count=1", state, instr_count);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] ex [8] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL lw cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd2) begin
            miscompares++;
            $display("FAIL lw_retire: state=%0d count=%0d expected state=0 count=2", state, instr_count);
        end
    endtask

    task automatic test_beq(input logic z, input logic [3:0] exp_count);
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd8};
        logic [16:0] ex [3] = '{C_FETCH_R, C_DECODE, C_BR_Z0};
        ex[2] = z ? C_BR_Z1 : C_BR_Z0;
        opcode = 6'b000100;
        zero   = z;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL beq(zero=%0d) cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", z, i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        zero = 1'b0;
        vectors++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            miscompares++;
            $display("FAIL beq_retire: state=%0d count=%0d expected state=0 count=%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [5] = '{4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
        logic        rd [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [16:0] ex [5] = '{C_FETCH_W, C_FETCH_R, C_DECODE, C_EXECUTE, C_ALUWB};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rd[i];
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL rtype cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd5) begin
            miscompares++;
            $display("FAIL rtype_retire: state=%0d count=%0d expected state=0 count=5", state, instr_count);
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [16:0] ex [5] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR_W, C_MEMWR_R};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rd[i];
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL sw cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd6) begin
            miscompares++;
            $display("FAIL sw_retire: state=%0d count=%0d expected state=0 count=6", state, instr_count);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [2] = '{4'd0, 4'd1};
        logic [16:0] ex [2] = '{C_FETCH_R, C_DEC_ILL};
        opcode = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL illegal cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd7) begin
            miscompares++;
            $display("FAIL illegal_retire: state=%0d count=%0d expected state=0 count=7", state, instr_count);
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd2};
        logic [16:0] ex [3] = '{C_FETCH_R, C_DECODE, C_MEMADR};
        opcode = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (state !== st[i] || ctrl !== ex[i]) begin
                miscompares++;
                $display("FAIL rst_sw cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", i, state, ctrl, st[i], ex[i]);
            end
            next_cycle();
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd5 || ctrl !== C_MEMWR_W) begin
            miscompares++;
            $display("FAIL rst_sw_wait: state=%0d ctrl=%b expected state=5 ctrl=%b", state, ctrl, C_MEMWR_W);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd5 || ctrl !== C_ZERO) begin
            miscompares++;
            $display("FAIL rst_abort_same_cycle: state=%0d ctrl=%b expected state=5 ctrl=%b", state, ctrl, C_ZERO);
        end
        next_cycle();
        vectors++;
        if (state !== 4'd0 || instr_count !== 4'd0 || ctrl !== C_ZERO) begin
            miscompares++;
            $display("FAIL rst_abort_after_edge: state=%0d count=%0d ctrl=%b expected state=0 count=0 ctrl=%b", state, instr_count, ctrl, C_ZERO);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_FETCH_W) begin
            miscompares++;
            $display("FAIL rst_release_fetch: ctrl=%b expected=%b", ctrl, C_FETCH_W);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd11};
        logic [16:0] ex [3] = '{C_FETCH_R, C_DECODE, C_JUMP};
        logic [3:0]  exp_count;
        opcode    = 6'b000010;
        mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 3; i++) begin
                #1;
                vectors++;
                if (state !== st[i] || ctrl !== ex[i]) begin
                    miscompares++;
                    $display("FAIL jump %0d cycle %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", k, i, state, ctrl, st[i], ex[i]);
                end
                next_cycle();
            end
            exp_count = 4'(k + 1);
            vectors++;
            if (instr_count !== exp_count) begin
                miscompares++;
                $display("FAIL jump_count after %0d: count=%0d expected=%0d", k + 1, instr_count, exp_count);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_beq(1'b1, 4'd3);
        test_beq(1'b0, 4'd4);
        test_rtype();
        test_sw_wait();
        test_illegal();
        test_reset_mid_memwr();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
